// File: rtl/hdmi_reconfig_sequencer_pkg.sv
// Shared definitions for the HDMI mode-change sequencer: mode codes, FSM states and
// the mode-code validity check also used by the video-config decoder.
package hdmi_reconfig_sequencer_pkg;

    localparam logic [6:0] MODE_1080P     = 7'h00;
    localparam logic [6:0] MODE_GRP0_LAST = 7'h0B;
    localparam logic [6:0] MODE_GRP1_0    = 7'h10;
    localparam logic [6:0] MODE_GRP2_0    = 7'h20;
    localparam logic [6:0] MODE_576I_0    = 7'h40;

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StBlank,
        StReconf,
        StLockWait,
        StRelease,
        StFail
    } seq_state_e;

    // Groups 1..3 each hold four codes, so only bits [6:2] need comparing.
    function automatic logic is_valid_mode(input logic [6:0] m);
        return (m <= MODE_GRP0_LAST) ||
               (m[6:2] == MODE_GRP1_0[6:2]) ||
               (m[6:2] == MODE_GRP2_0[6:2]) ||
               (m[6:2] == MODE_576I_0[6:2]);
    endfunction

endpackage

// File: rtl/hdmi_reconfig_sequencer_if.sv
// Handshake between the mode-change sequencer and the pixel-PLL reconfiguration engine.
interface hdmi_reconfig_sequencer_if;

    logic       pll_reconf_start;
    logic [6:0] pll_reconf_mode;
    logic       pll_reconf_busy;
    logic       pll_locked;

    modport master (
        output pll_reconf_start,
        output pll_reconf_mode,
        input  pll_reconf_busy,
        input  pll_locked
    );

    modport slave (
        input  pll_reconf_start,
        input  pll_reconf_mode,
        output pll_reconf_busy,
        output pll_locked
    );

endinterface

// File: rtl/hdmi_reconfig_timer.sv
// Loadable saturating cycle counter with terminal-count compare, shared by every
// sequencer state.
module hdmi_reconfig_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/hdmi_reconfig_sequencer.sv
// Sequences an HDMI mode change: debounce, blank, hold timing in reset, reconfigure the
// pixel PLL, qualify lock, then publish the new mode code.
module hdmi_reconfig_sequencer
    import hdmi_reconfig_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLANK_CYCLES    = 1024,
    parameter int unsigned RECONF_TIMEOUT  = 65535,
    parameter int unsigned LOCK_CYCLES     = 4096,
    parameter int unsigned SETTLE_CYCLES   = 256,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 mode_in,
    hdmi_reconfig_sequencer_if.master  pll_if,
    output logic                       video_reset,
    output logic                       video_blank,
    output logic [6:0]                 mode_out,
    output logic                       busy,
    output logic                       error
);

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
    localparam int unsigned WallW  = CNT_W + 2;

    localparam logic [CNT_W-1:0]  DEB_LIM    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLANK_LIM  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RECONF_LIM = CNT_W'(RECONF_TIMEOUT);
    localparam logic [CNT_W-1:0]  LOCK_LIM   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LIM = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WallW-1:0]  WALL_LIM   = WallW'(4 * LOCK_CYCLES - 1);
    localparam logic [RetryW-1:0] RETRY_LIM  = RetryW'(MAX_RETRY);

    seq_state_e        state_q, state_d;
    logic [6:0]        cand_q, cand_d;
    logic [6:0]        mode_out_q, mode_out_d;
    logic [6:0]        reconf_mode_q, reconf_mode_d;
    logic              start_q, start_d;
    logic              video_reset_q, video_reset_d;
    logic              video_blank_q, video_blank_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              seen_q, seen_d;
    logic              fail_lock_q, fail_lock_d;
    logic [WallW-1:0]  wall_q, wall_d;

    logic              tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0]  tmr_limit;
    logic [6:0]        mode_new;
    logic [RetryW-1:0] retry_inc;
    logic              start_ok;
    logic              unused_mode_msb;

    assign mode_new        = mode_in[6:0];
    assign unused_mode_msb = mode_in[7];
    assign retry_inc       = retry_q + RetryW'(1);
    // After giving up, the failed code must not immediately relaunch itself.
    assign start_ok = is_valid_mode(mode_new) && (mode_new != mode_out_q) &&
                      !(fail_lock_q && (mode_new == cand_q));

    hdmi_reconfig_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (tmr_clr),
        .en_i       (tmr_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .limit_i    (tmr_limit),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        mode_out_d    = mode_out_q;
        reconf_mode_d = reconf_mode_q;
        start_d       = 1'b0;
        video_reset_d = video_reset_q;
        video_blank_d = video_blank_q;
        busy_d        = busy_q;
        error_d       = error_q;
        retry_d       = retry_q;
        seen_d        = seen_q;
        fail_lock_d   = fail_lock_q;
        wall_d        = wall_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        tmr_limit     = '1;

        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d     = StDebounce;
                    cand_d      = mode_new;
                    retry_d     = '0;
                    fail_lock_d = 1'b0;
                    tmr_clr     = 1'b1;
                end
            end
            StDebounce: begin
                tmr_limit = DEB_LIM;
                if (mode_new != cand_q) begin
                    cand_d  = mode_new;
                    tmr_clr = 1'b1;
                    if (!is_valid_mode(mode_new) || (mode_new == mode_out_q)) begin
                        state_d = StIdle;
                    end
                end else if (tmr_tc) begin
                    state_d       = StBlank;
                    tmr_clr       = 1'b1;
                    busy_d        = 1'b1;
                    video_blank_d = 1'b1;
                    video_reset_d = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StBlank: begin
                tmr_limit = BLANK_LIM;
                if (tmr_tc) begin
                    state_d       = StReconf;
                    tmr_clr       = 1'b1;
                    start_d       = 1'b1;
                    reconf_mode_d = cand_q;
                    seen_d        = 1'b0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StReconf: begin
                tmr_limit = RECONF_LIM;
                if (pll_if.pll_reconf_busy) begin
                    seen_d = 1'b1;
                end
                if (seen_q && !pll_if.pll_reconf_busy) begin
                    state_d = StLockWait;
                    tmr_clr = 1'b1;
                    wall_d  = '0;
                end else if (tmr_tc) begin
                    state_d = StFail;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StLockWait: begin
                tmr_limit = LOCK_LIM;
                wall_d    = wall_q + WallW'(1);
                if (pll_if.pll_locked && tmr_tc) begin
                    state_d       = StRelease;
                    tmr_clr       = 1'b1;
                    video_reset_d = 1'b0;
                    mode_out_d    = cand_q;
                end else begin
                    // Only an unbroken run of lock cycles qualifies.
                    tmr_en  = pll_if.pll_locked;
                    tmr_clr = !pll_if.pll_locked;
                    if (wall_q == WALL_LIM) begin
                        state_d = StFail;
                    end
                end
            end
            StRelease: begin
                tmr_limit = SETTLE_LIM;
                if (tmr_tc) begin
                    state_d       = StIdle;
                    video_blank_d = 1'b0;
                    busy_d        = 1'b0;
                    retry_d       = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StFail: begin
                tmr_clr = 1'b1;
                retry_d = retry_inc;
                if (retry_inc < RETRY_LIM) begin
                    state_d       = StReconf;
                    start_d       = 1'b1;
                    reconf_mode_d = cand_q;
                    seen_d        = 1'b0;
                end else begin
                    state_d     = StIdle;
                    error_d     = 1'b1;
                    busy_d      = 1'b0;
                    fail_lock_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            cand_q        <= MODE_1080P;
            mode_out_q    <= MODE_1080P;
            reconf_mode_q <= MODE_1080P;
            start_q       <= 1'b0;
            video_reset_q <= 1'b0;
            video_blank_q <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            retry_q       <= '0;
            seen_q        <= 1'b0;
            fail_lock_q   <= 1'b0;
            wall_q        <= '0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            mode_out_q    <= mode_out_d;
            reconf_mode_q <= reconf_mode_d;
            start_q       <= start_d;
            video_reset_q <= video_reset_d;
            video_blank_q <= video_blank_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            retry_q       <= retry_d;
            seen_q        <= seen_d;
            fail_lock_q   <= fail_lock_d;
            wall_q        <= wall_d;
        end
    end

    assign pll_if.pll_reconf_start = start_q;
    assign pll_if.pll_reconf_mode  = reconf_mode_q;
    assign video_reset             = video_reset_q;
    assign video_blank             = video_blank_q;
    assign mode_out                = mode_out_q;
    assign busy                    = busy_q;
    assign error                   = error_q;

endmodule

// File: tb/tb_hdmi_reconfig_sequencer.sv
// Directed bench for hdmi_reconfig_sequencer with shortened timing parameters and a
// simple PLL reconfig engine / lock model.
module tb_hdmi_reconfig_sequencer;

    localparam int DEB = 16;
    localparam int BLK = 64;
    localparam int TMO = 300;
    localparam int LCK = 256;
    localparam int STL = 32;
    localparam int RTY = 3;

    localparam int SEL_START = 0;
    localparam int SEL_VRST  = 1;
    localparam int SEL_BLANK = 2;
    localparam int SEL_BUSY  = 3;
    localparam int SEL_ERR   = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mode_in = 8'h00;
    logic       video_reset, video_blank, busy, error;
    logic [6:0] mode_out;

    hdmi_reconfig_sequencer_if pif ();

    int n_total = 0;
    int n_bad = 0;
    int n_starts = 0;
    bit eng_responds = 1'b1;
    int eng_busy_len = 100;
    int busy_left = 0;
    int lock_mode = 1;
    int lock_cnt = 0;

    hdmi_reconfig_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .BLANK_CYCLES    (BLK),
        .RECONF_TIMEOUT  (TMO),
        .LOCK_CYCLES     (LCK),
        .SETTLE_CYCLES   (STL),
        .MAX_RETRY       (RTY),
        .CNT_W           (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode_in     (mode_in),
        .pll_if      (pif),
        .video_reset (video_reset),
        .video_blank (video_blank),
        .mode_out    (mode_out),
        .busy        (busy),
        .error       (error)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            SEL_START: return pif.pll_reconf_start;
            SEL_VRST:  return video_reset;
            SEL_BLANK: return video_blank;
            SEL_BUSY:  return busy;
            default:   return error;
        endcase
    endfunction

    // Edges counted until the selected output equals val; expiry is itself a failure.
    task automatic wait_sig(input int sel, input logic val, input int max_cyc, output int cyc);
        logic s;
        cyc = 0;
        do begin
            step(1);
            cyc++;
            s = pick(sel);
        end while ((s !== val) && (cyc < max_cyc));
        if (s !== val) check_eq($sformatf("wait_sel%0d", sel), s, val);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_mode_out"}, mode_out, 7'h00);
        check_eq({pfx, "_reconf_mode"}, pif.pll_reconf_mode, 7'h00);
        check_eq({pfx, "_start"}, pif.pll_reconf_start, 1'b0);
        check_eq({pfx, "_video_reset"}, video_reset, 1'b0);
        check_eq({pfx, "_video_blank"}, video_blank, 1'b0);
        check_eq({pfx, "_busy"}, busy, 1'b0);
        check_eq({pfx, "_error"}, error, 1'b0);
    endtask

    // Start-pulse monitor: a pulse wider than one cycle shows up as extra counts.
    initial forever begin
        @(posedge clock);
        #1;
        if (pif.pll_reconf_start === 1'b1) n_starts++;
    end

    // Reconfig engine: busy rises the cycle after start and stays high eng_busy_len cycles.
    initial begin
        pif.pll_reconf_busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) pif.pll_reconf_busy = 1'b0;
            end else if ((pif.pll_reconf_start === 1'b1) && eng_responds) begin
                pif.pll_reconf_busy = 1'b1;
                busy_left = eng_busy_len;
            end
        end
    end

    // Lock model: 0 low, 1 high, 2 high with a one-cycle drop every 200 cycles.
    initial begin
        pif.pll_locked = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            lock_cnt++;
            case (lock_mode)
                0:       pif.pll_locked = 1'b0;
                1:       pif.pll_locked = 1'b1;
                default: pif.pll_locked = ((lock_cnt % 200) != 0);
            endcase
        end
    end

    initial begin
        int cyc;
        int s0;
        bit any_busy;

        // Power-on reset
        step(3);
        check_eq("por_start_in_reset", pif.pll_reconf_start, 1'b0);
        reset = 1'b0;
        step(1);
        check_reset_vals("por");
        step(5);

        // Basic sequence to mode 02
        s0 = n_starts;
        mode_in = 8'h02;
        wait_sig(SEL_START, 1'b1, 200, cyc);
        check_eq("t1_start_latency", cyc, DEB + BLK + 1);
        check_eq("t1_reconf_mode", pif.pll_reconf_mode, 7'h02);
        check_eq("t1_busy", busy, 1'b1);
        check_eq("t1_video_blank", video_blank, 1'b1);
        check_eq("t1_video_reset", video_reset, 1'b1);
        // engine busy 100 cycles starting one after start, fall seen next, then full lock
        wait_sig(SEL_VRST, 1'b0, 2000, cyc);
        check_eq("t1_release_latency", cyc, 1 + 100 + LCK);
        check_eq("t1_mode_out", mode_out, 7'h02);
        wait_sig(SEL_BLANK, 1'b0, 200, cyc);
        check_eq("t1_settle", cyc, STL);
        check_eq("t1_busy_end", busy, 1'b0);
        check_eq("t1_start_count", n_starts - s0, 1);

        // 02/03 bouncing never debounces; holding 03 runs exactly one sequence
        s0 = n_starts;
        any_busy = 1'b0;
        for (int i = 0; i < 25; i++) begin
            mode_in = (i % 2 == 0) ? 8'h02 : 8'h03;
            repeat (8) begin
                step(1);
                any_busy |= busy;
            end
        end
        check_eq("t2_no_busy_bounce", any_busy, 1'b0);
        mode_in = 8'h03;
        wait_sig(SEL_START, 1'b1, 200, cyc);
        check_eq("t2_start_latency", cyc, DEB + BLK + 1);
        check_eq("t2_reconf_mode", pif.pll_reconf_mode, 7'h03);
        wait_sig(SEL_BUSY, 1'b0, 2000, cyc);
        check_eq("t2_mode_out", mode_out, 7'h03);
        check_eq("t2_start_count", n_starts - s0, 1);

        // Invalid code ignored; bit 7 ignored
        mode_in = 8'h8C;
        any_busy = 1'b0;
        repeat (100) begin
            step(1);
            any_busy |= busy;
        end
        check_eq("t3_invalid_no_busy", any_busy, 1'b0);
        check_eq("t3_invalid_mode_out", mode_out, 7'h03);
        mode_in = 8'h85;
        wait_sig(SEL_START, 1'b1, 200, cyc);
        check_eq("t3_start_latency", cyc, DEB + BLK + 1);
        check_eq("t3_reconf_mode", pif.pll_reconf_mode, 7'h05);
        wait_sig(SEL_BUSY, 1'b0, 2000, cyc);
        check_eq("t3_mode_out", mode_out, 7'h05);

        // Engine never goes busy: three timeouts then sticky error
        eng_responds = 1'b0;
        mode_in = 8'h00;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check_eq("t4_rst_mode_out", mode_out, 7'h00);
        s0 = n_starts;
        mode_in = 8'h07;
        wait_sig(SEL_START, 1'b1, 200, cyc);
        check_eq("t4_start1_latency", cyc, DEB + BLK + 1);
        // timeout count TMO, one cycle in FAIL, then the new start
        wait_sig(SEL_START, 1'b1, 1000, cyc);
        check_eq("t4_start2_gap", cyc, TMO + 2);
        wait_sig(SEL_START, 1'b1, 1000, cyc);
        check_eq("t4_start3_gap", cyc, TMO + 2);
        wait_sig(SEL_ERR, 1'b1, 1000, cyc);
        check_eq("t4_error_gap", cyc, TMO + 2);
        check_eq("t4_video_blank", video_blank, 1'b1);
        check_eq("t4_video_reset", video_reset, 1'b1);
        check_eq("t4_mode_out", mode_out, 7'h00);
        check_eq("t4_busy", busy, 1'b0);
        step(500);
        check_eq("t4_start_count", n_starts - s0, 3);
        check_eq("t4_error_sticky", error, 1'b1);

        // Glitchy lock fails by wall-clock bound; clean lock on retry completes
        eng_responds = 1'b1;
        eng_busy_len = 20;
        lock_mode = 2;
        mode_in = 8'h21;
        wait_sig(SEL_START, 1'b1, 200, cyc);
        check_eq("t5_start_latency", cyc, DEB + BLK + 1);
        wait_sig(SEL_START, 1'b1, 3000, cyc);
        check_eq("t5_retry_gap", cyc, 1 + 20 + 4 * LCK + 1);
        lock_mode = 1;
        wait_sig(SEL_VRST, 1'b0, 1000, cyc);
        check_eq("t5_release_latency", cyc, 1 + 20 + LCK);
        check_eq("t5_mode_out", mode_out, 7'h21);
        check_eq("t5_error_still_set", error, 1'b1);
        wait_sig(SEL_BUSY, 1'b0, 200, cyc);
        check_eq("t5_video_blank", video_blank, 1'b0);

        // Mode change during LOCK_WAIT, then reset in the middle of the next RECONF
        eng_busy_len = 100;
        mode_in = 8'h02;
        wait_sig(SEL_START, 1'b1, 200, cyc);
        check_eq("t6_start_latency", cyc, DEB + BLK + 1);
        step(200);
        mode_in = 8'h11;
        wait_sig(SEL_BUSY, 1'b0, 2000, cyc);
        check_eq("t6_mode_out_first", mode_out, 7'h02);
        wait_sig(SEL_START, 1'b1, 500, cyc);
        check_eq("t6_reconf_mode_second", pif.pll_reconf_mode, 7'h11);
        step(10);
        check_eq("t6_busy_mid_reconf", busy, 1'b1);
        reset = 1'b1;
        step(1);
        check_reset_vals("t6_rst");
        reset = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
